alu_writeback_stage: RTL

//  Pipeline stage directly downstream of the ALU. Captures each ALU result with its NZCV

---
 rtl/alu_writeback_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// Write-back stage behind the ALU: a small valid/ready FIFO of results and control bits,
// plus the architectural NZCV register committed when flag-setting entries retire.
module alu_writeback_stage #(
  parameter int DATA_W   = 32,
  parameter int REGIDX_W = 4,
  parameter int DEPTH    = 2   // power of 2, at least 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_result,
  input  logic [3:0]              in_flags,
  input  logic [REGIDX_W-1:0]     in_rd,
  input  logic                    in_wr_en,
  input  logic                    in_set_flg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_result,
  output logic [REGIDX_W-1:0]     out_rd,
  output logic                    out_wr_en,
  output logic [3:0]              nzcv,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]   result_mem_q  [DEPTH];
  logic [3:0]          flags_mem_q   [DEPTH];
  logic [REGIDX_W-1:0] rd_mem_q      [DEPTH];
  logic                wr_en_mem_q   [DEPTH];
  logic                set_flg_mem_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          nzcv_q, nzcv_d;

  // Registered copy of the head entry; it keeps its last value while the FIFO is empty.
  logic [DATA_W-1:0]   head_result_q, head_result_d;
  logic [3:0]          head_flags_q, head_flags_d;
  logic [REGIDX_W-1:0] head_rd_q, head_rd_d;
  logic                head_wr_en_q, head_wr_en_d;
  logic                head_set_flg_q, head_set_flg_d;

  logic                push_s;
  logic                pop_s;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push_s   = in_valid && in_ready;
  assign pop_s    = out_valid_q && out_ready;

  // Pointer, occupancy and status next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    nzcv_d   = nzcv_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop_s && head_set_flg_q) begin
      nzcv_d = head_flags_q;
    end else begin
      nzcv_d = nzcv_q;
    end
    out_valid_d = (count_d != {CNT_W{1'b0}});
  end

  // Next head: the entry being pushed bypasses storage when it becomes the head this edge
  always_comb begin
    head_result_d  = head_result_q;
    head_flags_d   = head_flags_q;
    head_rd_d      = head_rd_q;
    head_wr_en_d   = head_wr_en_q;
    head_set_flg_d = head_set_flg_q;
    if (count_d != {CNT_W{1'b0}}) begin
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
        head_result_d  = in_result;
        head_flags_d   = in_flags;
        head_rd_d      = in_rd;
        head_wr_en_d   = in_wr_en;
        head_set_flg_d = in_set_flg;
      end else begin
        head_result_d  = result_mem_q[rd_ptr_d];
        head_flags_d   = flags_mem_q[rd_ptr_d];
        head_rd_d      = rd_mem_q[rd_ptr_d];
        head_wr_en_d   = wr_en_mem_q[rd_ptr_d];
        head_set_flg_d = set_flg_mem_q[rd_ptr_d];
      end
    end else begin
      head_result_d  = head_result_q;
      head_flags_d   = head_flags_q;
      head_rd_d      = head_rd_q;
      head_wr_en_d   = head_wr_en_q;
      head_set_flg_d = head_set_flg_q;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_mem_q[i]  <= {DATA_W{1'b0}};
        flags_mem_q[i]   <= 4'b0000;
        rd_mem_q[i]      <= {REGIDX_W{1'b0}};
        wr_en_mem_q[i]   <= 1'b0;
        set_flg_mem_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      result_mem_q[wr_ptr_q]  <= in_result;
      flags_mem_q[wr_ptr_q]   <= in_flags;
      rd_mem_q[wr_ptr_q]      <= in_rd;
      wr_en_mem_q[wr_ptr_q]   <= in_wr_en;
      set_flg_mem_q[wr_ptr_q] <= in_set_flg;
    end
  end

  // Control, status and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      out_valid_q    <= 1'b0;
      nzcv_q         <= 4'b0000;
      head_result_q  <= {DATA_W{1'b0}};
      head_flags_q   <= 4'b0000;
      head_rd_q      <= {REGIDX_W{1'b0}};
      head_wr_en_q   <= 1'b0;
      head_set_flg_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      nzcv_q         <= nzcv_d;
      head_result_q  <= head_result_d;
      head_flags_q   <= head_flags_d;
      head_rd_q      <= head_rd_d;
      head_wr_en_q   <= head_wr_en_d;
      head_set_flg_q <= head_set_flg_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = head_result_q;
  assign out_rd     = head_rd_q;
  assign out_wr_en  = head_wr_en_q;
  assign nzcv       = nzcv_q;
  assign count      = count_q;

endmodule
